// File: rtl/uart_imem_loader.sv
// Assembles little-endian 32-bit instruction words from UART bytes and writes them
// into instruction memory, holding the core in reset until a sentinel word ends the load.
module uart_imem_loader #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    input  logic              mem_wr_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              write_done,
    output logic              cpu_rst,
    output logic              load_err
);

    // One extra address bit so "address == DEPTH" is representable when DEPTH == 2**ADDR_W.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [1:0]         r_byte_cnt, w_byte_cnt_nxt;
    logic [23:0]        r_asm,      w_asm_nxt;
    logic               r_wr_en,    w_wr_en_nxt;
    logic [CNT_W-1:0]   r_wr_addr,  w_wr_addr_nxt;
    logic [31:0]        r_wr_data,  w_wr_data_nxt;
    logic [TMO_W-1:0]   r_tmo,      w_tmo_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_err,      w_err_nxt;
    logic               r_cpu_rst,  w_cpu_rst_nxt;
    logic               w_ack;
    logic               w_blocked;
    logic [31:0]        w_word;

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_tmo      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rst  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_asm      <= w_asm_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_tmo      <= w_tmo_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_cpu_rst  <= w_cpu_rst_nxt;
        end
    end

    // Next-state logic: write handshake, byte assembly, word completion, idle timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_asm_nxt      = r_asm;
        w_wr_en_nxt    = r_wr_en;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_tmo_nxt      = r_tmo;
        w_ack          = r_wr_en && mem_wr_ready;
        w_blocked      = r_wr_en && !mem_wr_ready;
        w_word         = {rx_data, r_asm};

        case (r_state)
            S_DONE, S_ERR: begin
                w_wr_en_nxt = 1'b0;
                w_tmo_nxt   = '0;
            end
            default: begin
                if (rx_break) begin
                    w_state_nxt    = S_IDLE;
                    w_wr_en_nxt    = 1'b0;
                    w_byte_cnt_nxt = 2'd0;
                    w_wr_addr_nxt  = '0;
                    w_tmo_nxt      = '0;
                end else begin
                    if (w_ack) begin
                        w_wr_en_nxt   = 1'b0;
                        w_wr_addr_nxt = r_wr_addr + CNT_W'(1);
                    end

                    if (rx_valid) begin
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    w_asm_nxt[7:0]   = rx_data;
                            2'd1:    w_asm_nxt[15:8]  = rx_data;
                            2'd2:    w_asm_nxt[23:16] = rx_data;
                            default: begin
                                if (w_blocked) begin
                                    w_state_nxt = S_ERR;
                                    w_wr_en_nxt = 1'b0;
                                end else if (w_word == SENTINEL) begin
                                    w_state_nxt = S_DONE;
                                end else if (w_wr_addr_nxt == CNT_W'(DEPTH)) begin
                                    w_state_nxt = S_ERR;
                                    w_wr_en_nxt = 1'b0;
                                end else begin
                                    w_wr_en_nxt   = 1'b1;
                                    w_wr_data_nxt = w_word;
                                end
                            end
                        endcase
                    end

                    // Partial word abandoned after a full idle window while collecting.
                    if (r_state == S_COLLECT && !rx_valid && r_byte_cnt != 2'd0) begin
                        if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                            w_tmo_nxt      = '0;
                            w_byte_cnt_nxt = 2'd0;
                        end else begin
                            w_tmo_nxt = r_tmo + TMO_W'(1);
                        end
                    end else begin
                        w_tmo_nxt = '0;
                    end

                    if (w_state_nxt != S_DONE && w_state_nxt != S_ERR) begin
                        if (w_wr_en_nxt)
                            w_state_nxt = S_WRITE;
                        else if (w_byte_cnt_nxt != 2'd0)
                            w_state_nxt = S_COLLECT;
                        else
                            w_state_nxt = S_IDLE;
                    end
                end
            end
        endcase

        w_done_nxt    = (w_state_nxt == S_DONE);
        w_err_nxt     = (w_state_nxt == S_ERR);
        w_cpu_rst_nxt = (w_state_nxt != S_DONE);
    end

    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr[ADDR_W-1:0];
    assign mem_wr_data = r_wr_data;
    assign write_done  = r_done;
    assign cpu_rst     = r_cpu_rst;
    assign load_err    = r_err;

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the word-address width of the instruction memory.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of writable words (DEPTH <= 2**ADDR_W).
REQ-003 Parameter TIMEOUT_CYC, default 100000, SHALL set the inter-byte idle limit in clk cycles for a partial word.
REQ-004 Port list SHALL be:
  clk  input  1  system clock, all logic on rising edge
  resetn  input  1  asynchronous active-low reset
  rx_valid  input  1  one-cycle pulse, rx_data holds a received byte
  rx_data  input  8  received UART byte
  rx_break  input  1  one-cycle pulse, UART BREAK detected
  mem_wr_ready  input  1  memory accepts write this cycle
  mem_wr_en  output  1  write request to instruction memory
  mem_wr_addr  output  ADDR_W  word address of write
  mem_wr_data  output  32  instruction word
  write_done  output  1  program load complete, sticky
  cpu_rst  output  1  active-high hold-reset to core
  load_err  output  1  load failed, sticky

Function
REQ-005 SHALL implement states IDLE, COLLECT, WRITE, DONE, ERR.
REQ-006 Bytes SHALL assemble little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]; a 2-bit byte counter SHALL wrap 3->0 on the 4th byte.
REQ-007 IDLE -> COLLECT on first rx_valid; COLLECT -> WRITE when the 4th byte is accepted.
REQ-008 Completed word SHALL be copied to a holding register driving mem_wr_data; mem_wr_en SHALL rise the cycle after the 4th-byte rx_valid (latency 1).
REQ-009 mem_wr_en, mem_wr_addr, mem_wr_data SHALL stay stable until a cycle with mem_wr_en && mem_wr_ready; next cycle mem_wr_en SHALL drop, mem_wr_addr SHALL increment by 1, state -> COLLECT (or IDLE if byte counter is 0 and no partial word).
REQ-010 Bytes arriving during WRITE SHALL be accepted into the assembly register; if a 4th byte completes while the previous write is still pending, state SHALL go to ERR.
REQ-011 A completed word equal to 32'hFFFFFFFF SHALL NOT be written; the next cycle state SHALL go to DONE.
REQ-012 In DONE: write_done=1, cpu_rst=0, all rx_valid/rx_break ignored until reset.
REQ-013 If a word completes (non-sentinel) when mem_wr_addr == DEPTH, no write SHALL occur and state SHALL go to ERR.
REQ-014 In ERR: load_err=1, cpu_rst=1, write_done=0, mem_wr_en=0, inputs ignored until reset.
REQ-015 rx_break in IDLE/COLLECT/WRITE SHALL abort: drop any pending write, clear byte counter and mem_wr_addr to 0, go to IDLE (restart load).
REQ-016 In COLLECT with byte counter != 0, TIMEOUT_CYC consecutive cycles without rx_valid SHALL discard the partial word, clear the byte counter, keep mem_wr_addr, and go to IDLE.
REQ-017 rx_break and rx_valid in the same cycle: rx_break SHALL win, byte discarded.
REQ-018 mem_wr_ready SHALL be ignored when mem_wr_en=0.
REQ-019 cpu_rst SHALL be 1 in every state except DONE.

Reset
REQ-020 resetn=0 SHALL asynchronously force: state IDLE, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, byte counter 0, timeout counter 0, write_done=0, load_err=0, cpu_rst=1.
REQ-021 Reset asserted mid-word or mid-write SHALL discard all progress; no write SHALL complete after resetn falls.
REQ-022 Release of resetn SHALL take effect on the first rising clk edge after deassertion.

Verification
REQ-023 Bytes 13,01,01,FD with mem_wr_ready=1 -> one write addr 0 data 32'hFD010113, mem_wr_en high exactly 1 cycle, addr then 1.
REQ-024 Words 32'h02812623, 32'h03010413, then FF,FF,FF,FF -> writes to addr 0,1 only; write_done=1, cpu_rst=0 next cycle after 4th FF.
REQ-025 mem_wr_ready held 0 for 20 cycles after word -> addr/data stable, mem_wr_en high all 20 cycles, one write on ready.
REQ-026 Bytes 13,01 then idle TIMEOUT_CYC cycles, then 23,26,81,02 -> single write 32'h02812623 at addr 0.
REQ-027 DEPTH=4, five non-sentinel words -> four writes addr 0..3, then load_err=1, cpu_rst=1, write_done=0.
REQ-028 rx_break after two full words and one byte -> addr back to 0, next full word written to addr 0; resetn pulsed mid-write -> mem_wr_en=0 immediately, all outputs at reset values.
